hash_request_sequencer: RTL and testbench

Front-end stage directly upstream of the hash-table controller. It buffers incoming read/write/delete requests in a small FIFO and computes one bucket address per table. It issues the table read, waits out the table read latency, then presents key, data, operation and hash addresses to the controller, qualified by a one-cycle clock-enable pulse. Only one request is in flight at a time, so the controller never sees stale table contents.

---
 rtl/hash_request_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_hash_request_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_request_sequencer.sv
// Request FIFO plus one-at-a-time table-read sequencer feeding the hash-table controller.
// Per-table bucket hashes are taken from the FIFO head and held until the request executes.
module hash_request_sequencer #(
  parameter int KEY_WIDTH           = 8,
  parameter int DATA_WIDTH          = 32,
  parameter int NUMBER_OF_TABLES    = 3,
  parameter int HASH_TABLE_MAX_SIZE = 2,
  parameter int FIFO_DEPTH          = 4,
  parameter int READ_LATENCY        = 1
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          req_valid_i,
  output logic                                          req_ready_o,
  input  logic [1:0]                                    req_op_i,
  input  logic [KEY_WIDTH-1:0]                          req_key_i,
  input  logic [DATA_WIDTH-1:0]                         req_data_i,
  output logic                                          tbl_rd_en_o,
  output logic [HASH_TABLE_MAX_SIZE*NUMBER_OF_TABLES-1:0] tbl_rd_adr_o,
  output logic                                          ctrl_clk_en_o,
  output logic [1:0]                                    ctrl_op_o,
  output logic [KEY_WIDTH-1:0]                          ctrl_key_o,
  output logic [DATA_WIDTH-1:0]                         ctrl_data_o,
  output logic [HASH_TABLE_MAX_SIZE*NUMBER_OF_TABLES-1:0] ctrl_hash_adr_o,
  output logic                                          busy_o,
  output logic [15:0]                                   ops_done_o
);

  // state  | meaning
  // IDLE   | nothing in flight; pop head when FIFO non-empty (NOPs dropped)
  // ISSUE  | table read strobe, latency timer loaded
  // WAIT   | table read in progress, READ_LATENCY cycles
  // EXEC   | controller clock-enable pulse; may pop the next request

  localparam int HW      = HASH_TABLE_MAX_SIZE;
  localparam int ADR_W   = HW * NUMBER_OF_TABLES;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 2 + KEY_WIDTH + DATA_WIDTH;
  localparam int CHUNKS  = (KEY_WIDTH + HW - 1) / HW;
  localparam int PAD_W   = CHUNKS * HW;
  localparam int LAT_W   = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_EXEC} state_t;

  function automatic logic [HW-1:0] bucket_hash(input logic [KEY_WIDTH-1:0] key, input int tbl);
    logic [KEY_WIDTH-1:0] rot;
    logic [PAD_W-1:0]     padded;
    logic [HW-1:0]        acc;
    int                   sh;
    sh     = tbl % KEY_WIDTH;
    rot    = (key << sh) | (key >> (KEY_WIDTH - sh));
    padded = '0;
    padded[KEY_WIDTH-1:0] = rot;
    acc    = '0;
    for (int c = 0; c < CHUNKS; c++) acc = acc ^ padded[c*HW +: HW];
    return acc;
  endfunction

  state_t state, state_n;

  logic [ENTRY_W-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  empty, full, push, pop, load;
  logic [ENTRY_W-1:0]    head;
  logic [1:0]            head_op;
  logic [KEY_WIDTH-1:0]  head_key;
  logic [DATA_WIDTH-1:0] head_data;
  logic [ADR_W-1:0]      head_hash;

  logic [1:0]            hold_op;
  logic [KEY_WIDTH-1:0]  hold_key;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [ADR_W-1:0]      hold_hash;
  logic [LAT_W-1:0]      lat_cnt;
  logic                  lat_load;

  assign empty       = (count == '0);
  assign full        = (count == CNT_W'(FIFO_DEPTH));
  assign req_ready_o = !full;
  assign push        = req_valid_i && !full;

  assign head      = mem[rd_ptr];
  assign head_op   = head[ENTRY_W-1 -: 2];
  assign head_key  = head[DATA_WIDTH +: KEY_WIDTH];
  assign head_data = head[DATA_WIDTH-1:0];

  always_comb begin
    head_hash = '0;
    for (int t = 0; t < NUMBER_OF_TABLES; t++) head_hash[t*HW +: HW] = bucket_hash(head_key, t);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req_op_i, req_key_i, req_data_i};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_n  = state;
    pop      = 1'b0;
    load     = 1'b0;
    lat_load = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_op != 2'b00) begin
            load    = 1'b1;
            state_n = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        lat_load = 1'b1;
        state_n  = S_WAIT;
      end
      S_WAIT: begin
        if (lat_cnt == '0) state_n = S_EXEC;
      end
      S_EXEC: begin
        state_n = S_IDLE;
        if (!empty) begin
          pop = 1'b1;
          if (head_op != 2'b00) begin
            load    = 1'b1;
            state_n = S_ISSUE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      lat_cnt    <= '0;
      hold_op    <= '0;
      hold_key   <= '0;
      hold_data  <= '0;
      hold_hash  <= '0;
      ops_done_o <= '0;
    end else begin
      state <= state_n;
      if (lat_load)
        lat_cnt <= LAT_W'(READ_LATENCY - 1);
      else if (state == S_WAIT && lat_cnt != '0)
        lat_cnt <= lat_cnt - 1'b1;
      if (load) begin
        hold_op   <= head_op;
        hold_key  <= head_key;
        hold_data <= head_data;
        hold_hash <= head_hash;
      end
      if (state == S_EXEC && ops_done_o != 16'hFFFF) ops_done_o <= ops_done_o + 1'b1;
    end
  end

  assign tbl_rd_en_o     = (state == S_ISSUE);
  assign ctrl_clk_en_o   = (state == S_EXEC);
  assign ctrl_op_o       = (state == S_EXEC) ? hold_op : 2'b00;
  assign tbl_rd_adr_o    = hold_hash;
  assign ctrl_hash_adr_o = hold_hash;
  assign ctrl_key_o      = hold_key;
  assign ctrl_data_o     = hold_data;
  assign busy_o          = (state != S_IDLE) || !empty;

endmodule

// File: tb/tb_hash_request_sequencer.sv
// Bench for hash_request_sequencer: transaction-level model compared every cycle,
// plus directed literal checks, and a second READ_LATENCY=3 instance for the latency case.
module tb_hash_request_sequencer;
  localparam int RL    = 1;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid_i = 1'b0;
  logic [1:0]  req_op_i = '0;
  logic [7:0]  req_key_i = '0;
  logic [31:0] req_data_i = '0;
  logic        req_ready_o, tbl_rd_en_o, ctrl_clk_en_o, busy_o;
  logic [5:0]  tbl_rd_adr_o, ctrl_hash_adr_o;
  logic [1:0]  ctrl_op_o;
  logic [7:0]  ctrl_key_o;
  logic [31:0] ctrl_data_o;
  logic [15:0] ops_done_o;

  logic        r3_valid = 1'b0;
  logic [1:0]  r3_op = '0;
  logic [7:0]  r3_key = '0;
  logic [31:0] r3_data = '0;
  logic        r3_ready, r3_rd_en, r3_clk_en, r3_busy;
  logic [5:0]  r3_rd_adr, r3_hash;
  logic [1:0]  r3_ctrl_op;
  logic [7:0]  r3_ctrl_key;
  logic [31:0] r3_ctrl_data;
  logic [15:0] r3_ops;

  hash_request_sequencer #(.READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_key_i(req_key_i), .req_data_i(req_data_i),
    .tbl_rd_en_o(tbl_rd_en_o), .tbl_rd_adr_o(tbl_rd_adr_o),
    .ctrl_clk_en_o(ctrl_clk_en_o), .ctrl_op_o(ctrl_op_o), .ctrl_key_o(ctrl_key_o),
    .ctrl_data_o(ctrl_data_o), .ctrl_hash_adr_o(ctrl_hash_adr_o),
    .busy_o(busy_o), .ops_done_o(ops_done_o));

  hash_request_sequencer #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid_i(r3_valid), .req_ready_o(r3_ready), .req_op_i(r3_op),
    .req_key_i(r3_key), .req_data_i(r3_data),
    .tbl_rd_en_o(r3_rd_en), .tbl_rd_adr_o(r3_rd_adr),
    .ctrl_clk_en_o(r3_clk_en), .ctrl_op_o(r3_ctrl_op), .ctrl_key_o(r3_ctrl_key),
    .ctrl_data_o(r3_ctrl_data), .ctrl_hash_adr_o(r3_hash),
    .busy_o(r3_busy), .ops_done_o(r3_ops));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Three tables of 2-bit buckets: rotate by t, XOR the four 2-bit slices.
  function automatic logic [5:0] model_hash(input logic [7:0] k);
    logic [15:0] dbl;
    logic [7:0]  r;
    logic [5:0]  res;
    res = '0;
    for (int t = 0; t < 3; t++) begin
      dbl = {k, k} >> (8 - t);
      r   = dbl[7:0];
      res[t*2 +: 2] = r[1:0] ^ r[3:2] ^ r[5:4] ^ r[7:6];
    end
    return res;
  endfunction

  typedef struct packed {
    logic [1:0]  op;
    logic [7:0]  key;
    logic [31:0] data;
  } req_t;

  // Model: pending queue, the request in flight, and cycles elapsed since it was popped.
  req_t mq[$];
  req_t m_hold, m_new, m_pop;
  bit   m_inflight = 0;
  bit   m_valid = 0;
  int   m_age = 0;
  int   m_ops = 0;
  bit   m_push_ok, m_exec_now;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_hold = '0;
      m_inflight = 0;
      m_age = 0;
      m_ops = 0;
      m_valid = 1;
    end else if (m_valid) begin
      m_push_ok  = req_valid_i && (mq.size() < DEPTH);
      m_exec_now = m_inflight && (m_age == RL + 1);
      if (m_exec_now) begin
        if (m_ops < 65535) m_ops++;
        m_inflight = 0;
      end else if (m_inflight) begin
        m_age++;
      end
      if (!m_inflight && mq.size() > 0) begin
        m_pop = mq.pop_front();
        if (m_pop.op != 2'b00) begin
          m_hold = m_pop;
          m_inflight = 1;
          m_age = 0;
        end
      end
      if (m_push_ok) begin
        m_new.op = req_op_i;
        m_new.key = req_key_i;
        m_new.data = req_data_i;
        mq.push_back(m_new);
      end
    end
  end

  int   cyc = 0;
  int   pulse_cyc[$];
  logic [7:0] pulse_key[$];
  bit   e_rd, e_en;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (m_valid) begin
      e_rd = m_inflight && (m_age == 0);
      e_en = m_inflight && (m_age == RL + 1);
      chk("req_ready", req_ready_o, mq.size() < DEPTH);
      chk("busy", busy_o, m_inflight || mq.size() > 0);
      chk("tbl_rd_en", tbl_rd_en_o, e_rd);
      chk("tbl_rd_adr", tbl_rd_adr_o, model_hash(m_hold.key));
      chk("ctrl_clk_en", ctrl_clk_en_o, e_en);
      chk("ctrl_op", ctrl_op_o, e_en ? m_hold.op : 2'b00);
      chk("ctrl_key", ctrl_key_o, m_hold.key);
      chk("ctrl_data", ctrl_data_o, m_hold.data);
      chk("ctrl_hash", ctrl_hash_adr_o, model_hash(m_hold.key));
      chk("ops_done", ops_done_o, m_ops);
      if (ctrl_clk_en_o) begin
        pulse_cyc.push_back(cyc);
        pulse_key.push_back(ctrl_key_o);
      end
    end
  end

  // Present a request until accepted; called and returning at posedge+1.
  task automatic push_one(input logic [1:0] op, input logic [7:0] key,
                          input logic [31:0] data, input bit keep);
    bit acc;
    int n;
    n = 0;
    req_valid_i = 1'b1;
    req_op_i = op;
    req_key_i = key;
    req_data_i = data;
    do begin
      acc = req_ready_o;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("push_timeout", acc, 1'b1);
    if (!keep) req_valid_i = 1'b0;
  endtask

  int waits;
  logic [7:0] exp_keys[6];

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset and idle
    repeat (5) @(posedge clk);
    #1;
    chk("t1_ready", req_ready_o, 1'b1);
    chk("t1_busy", busy_o, 1'b0);
    chk("t1_clk_en", ctrl_clk_en_o, 1'b0);
    chk("t1_op", ctrl_op_o, 2'b00);
    chk("t1_ops", ops_done_o, 16'd0);

    // Single write, key 01
    push_one(2'b10, 8'h01, 32'hCAFE0001, 0);
    chk("t2_rd_en_e0", tbl_rd_en_o, 1'b0);
    @(posedge clk); #1;
    chk("t2_rd_en_e1", tbl_rd_en_o, 1'b1);
    chk("t2_rd_adr", tbl_rd_adr_o, 6'b01_10_01);
    @(posedge clk); #1;
    chk("t2_rd_en_e2", tbl_rd_en_o, 1'b0);
    chk("t2_clk_en_e2", ctrl_clk_en_o, 1'b0);
    @(posedge clk); #1;
    chk("t2_clk_en_e3", ctrl_clk_en_o, 1'b1);
    chk("t2_op", ctrl_op_o, 2'b10);
    chk("t2_data", ctrl_data_o, 32'hCAFE0001);
    @(posedge clk); #1;
    chk("t2_clk_en_e4", ctrl_clk_en_o, 1'b0);
    chk("t2_ops", ops_done_o, 16'd1);

    // One request, then five back-to-back with valid held high
    pulse_cyc.delete();
    pulse_key.delete();
    exp_keys[0] = 8'h10;
    push_one(2'b01, 8'h10, 32'h0000_0010, 0);
    for (int i = 0; i < 5; i++) begin
      exp_keys[i+1] = 8'h20 + 8'(i);
      push_one(2'(i % 3 + 1), 8'h20 + 8'(i), 32'hA000_0000 + 32'(i), 1);
    end
    chk("t3_ready_full", req_ready_o, 1'b0);
    req_valid_i = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    chk("t3_pulse_count", pulse_cyc.size(), 6);
    if (pulse_cyc.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("t3_order", pulse_key[i], exp_keys[i]);
      for (int i = 1; i < 6; i++) chk("t3_spacing", pulse_cyc[i] - pulse_cyc[i-1], 3);
    end
    chk("t3_ops", ops_done_o, 16'd7);

    // NOP followed by read of key B4
    pulse_cyc.delete();
    pulse_key.delete();
    push_one(2'b00, 8'h33, 32'h0, 1);
    push_one(2'b01, 8'hB4, 32'h0, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("t4_pulse_count", pulse_cyc.size(), 1);
    if (pulse_cyc.size() == 1) chk("t4_key", pulse_key[0], 8'hB4);
    chk("t4_hash", ctrl_hash_adr_o, model_hash(8'hB4));
    chk("t4_ops", ops_done_o, 16'd8);

    // Reset during WAIT with two entries queued
    push_one(2'b10, 8'h41, 32'h1, 1);
    push_one(2'b10, 8'h42, 32'h2, 1);
    push_one(2'b10, 8'h43, 32'h3, 0);
    chk("t5_in_wait_rd_en", tbl_rd_en_o, 1'b0);
    chk("t5_in_wait_busy", busy_o, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    pulse_cyc.delete();
    pulse_key.delete();
    repeat (10) @(posedge clk);
    #1;
    chk("t5_pulses", pulse_cyc.size(), 0);
    chk("t5_ready", req_ready_o, 1'b1);
    chk("t5_busy", busy_o, 1'b0);
    chk("t5_ops", ops_done_o, 16'd0);

    // READ_LATENCY=3 instance, single delete
    chk("t6_ready", r3_ready, 1'b1);
    r3_valid = 1'b1;
    r3_op = 2'b11;
    r3_key = 8'h55;
    r3_data = 32'hDEAD_0055;
    @(posedge clk); #1;
    r3_valid = 1'b0;
    waits = 0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      chk("t6_rd_en", r3_rd_en, k == 1);
      chk("t6_clk_en", r3_clk_en, k == 5);
      chk("t6_op", r3_ctrl_op, (k == 5) ? 2'b11 : 2'b00);
      if (r3_busy && !r3_rd_en && !r3_clk_en) waits++;
      if (k == 5) begin
        chk("t6_key", r3_ctrl_key, 8'h55);
        chk("t6_data", r3_ctrl_data, 32'hDEAD_0055);
        chk("t6_hash", r3_hash, model_hash(8'h55));
        chk("t6_rd_adr", r3_rd_adr, model_hash(8'h55));
      end
    end
    chk("t6_wait_cycles", waits, 3);
    chk("t6_ops", r3_ops, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
